idecode: RTL
============

# idecode

Instruction-decode stage of the venus pipeline. It sits directly downstream of the fetch stage and consumes that stage's `inst_o` and `inst_addr_o`. It splits each 32-bit word into fields, reads two operands from a 32x32 register file, and registers everything into the ID/EX pipeline register for execute. It also detects load-use hazards and drives the fetch stage's `stall_i`.

## Interface
Parameters:
- `ADDR`, 16, instruction address width
- `WORD`, 32, instruction/data width
- `NOP`, 32'h3C00_0000, bubble encoding, identical to the fetch stage's bubble

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; one clock, reset synchronous and active-low
- `inst_i`  in  WORD  instruction from fetch `inst_o`
- `inst_addr_i`  in  ADDR  its address, from fetch `inst_addr_o`
- `flush_i`  in  1  taken branch resolved in execute; kill the decode slot
- `wb_we_i`  in  1  register-file write enable, from writeback
- `wb_addr_i`  in  5  write register
- `wb_data_i`  in  WORD  write data
- `stall_o`  out  1  to fetch `stall_i`; combinational
- `op_o`  out  6  opcode
- `rd_o`  out  5  destination register
- `rs_data_o`, `rt_data_o`  out  WORD  operands
- `imm_o`  out  WORD  sign-extended `inst[15:0]`
- `pc_o`  out  ADDR  instruction address
- `is_load_o`  out  1  opcode is LOAD

## Operation
- Field map: op=[31:26], rd=[25:21], rs=[20:16], rt=[15:11], imm=[15:0].
- Opcode classes:
  - op[5:4]=00: reg-reg ALU, reads rs and rt.
  - op[5:4]=01: immediate ALU, reads rs only.
  - 6'h20 LOAD: reads rs.
  - 6'h21 STORE: reads rs and rt.
  - 6'h30 BEQ: reads rs and rt.
  - 6'h0F (NOP encoding): reads nothing.
- Source select: if `replay_v` is set, decode the replay register; otherwise decode `inst_i`/`inst_addr_i`.
- Hazard:
  - `stall_o` = `is_load_o` & (`rd_o`≠0) & (`rd_o` matches a register the selected instruction actually reads) & ~`flush_i`.
  - On a stall, the selected instruction and address are captured into the replay register and `replay_v`←1.
  - On a stall, the ID/EX register loads a bubble.
- Replay: on the cycle after a stall the replay entry is decoded normally and `replay_v`←0. The fetch stage outputs NOP while stalled, so `inst_i` is ignored that cycle.
- Flush: `flush_i`=1 → ID/EX loads a bubble and `replay_v`←0. Flush has priority over stall.
- Bubble: op=6'h0F, rd=0, operands=0, imm=0, pc=0, `is_load_o`=0.
- Register file:
  - r0 always reads 0, and writes to r0 are ignored.
  - A write in the same cycle as a read of the same register returns `wb_data_i` (write-before-read bypass).

## Timing
- Reset (sampled when `rst`=0 at the `clk` edge): all ID/EX outputs take the bubble value, `replay_v`=0, and register-file contents are cleared to 0. `stall_o` is therefore 0 during reset.
- Latency: an instruction present on `inst_i` at edge N appears on the outputs after edge N.
- Register-file write: committed at the edge where `wb_we_i`=1.
- Stall length:
  - A load-use hazard produces exactly one stall cycle, because the next ID/EX value is a bubble with `is_load_o`=0.
  - Two back-to-back loads into a dependent instruction stall only on the final dependency.
- Reset mid-stall drops the replay entry.

## Structure
- Shared package `venus_pkg`: opcode constants (OP_LOAD, OP_STORE, OP_BEQ, OP_NOP), the NOP word, and the field bit positions.
- Sub-module `regfile32x32`: two asynchronous read ports, one synchronous write port, r0 hardwired, bypass implemented inside.
- `idecode` itself contains the field decode, hazard logic, replay register and ID/EX register.

## Test plan
- Reset: hold `rst`=0 for 2 cycles → `op_o`=6'h0F, `stall_o`=0, all data outputs 0.
- Reg-reg ALU:
  - Stimulus: write r3=32'h0000_0005 and r4=32'h0000_0007 via writeback, then `inst_i`={6'h01,5'd1,5'd3,5'd4,11'd0}, `inst_addr_i`=16'h0010.
  - Response, next cycle: `rs_data_o`=5, `rt_data_o`=7, `rd_o`=1, `pc_o`=16'h0010.
- Immediate sign-extend: imm=16'hFFFE on a 01xxxx opcode → `imm_o`=32'hFFFF_FFFE.
- Load-use:
  - Stimulus: LOAD r2 followed by `inst_i` reading rs=r2.
  - Response: `stall_o`=1 for one cycle, one bubble on the outputs, then the dependent instruction issues with `pc_o` equal to its original address.
- Flush:
  - Stimulus: `flush_i`=1 during the replay cycle.
  - Response: outputs become a bubble, `replay_v` is cleared, `stall_o`=0.
- Bypass and r0:
  - Stimulus 1: `wb_we_i`=1 writing r5=32'hDEAD_BEEF while the decoded instruction reads r5. Response: `rs_data_o`=32'hDEAD_BEEF.
  - Stimulus 2: a write to r0. Response: r0 still reads 0.

Source files
------------

// File: rtl/venus_pkg.sv
// Shared venus pipeline definitions: opcodes, the bubble word, instruction field
// positions and the per-opcode operand-usage helpers.
package venus_pkg;

  localparam logic [5:0]  OP_LOAD  = 6'h20;
  localparam logic [5:0]  OP_STORE = 6'h21;
  localparam logic [5:0]  OP_BEQ   = 6'h30;
  localparam logic [5:0]  OP_NOP   = 6'h0F;
  localparam logic [31:0] NOP_WORD = 32'h3C00_0000;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 21;
  localparam int RS_HI  = 20;
  localparam int RS_LO  = 16;
  localparam int RT_HI  = 15;
  localparam int RT_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  // NOP shares the 00xxxx class encoding, so it is excluded first
  function automatic logic reads_rs(input logic [5:0] op);
    logic r;
    r = 1'b0;
    if (op == OP_NOP) begin
      r = 1'b0;
    end else if ((op[5:4] == 2'b00) || (op[5:4] == 2'b01)) begin
      r = 1'b1;
    end else if ((op == OP_LOAD) || (op == OP_STORE) || (op == OP_BEQ)) begin
      r = 1'b1;
    end else begin
      r = 1'b0;
    end
    return r;
  endfunction

  function automatic logic reads_rt(input logic [5:0] op);
    logic r;
    r = 1'b0;
    if (op == OP_NOP) begin
      r = 1'b0;
    end else if (op[5:4] == 2'b00) begin
      r = 1'b1;
    end else if ((op == OP_STORE) || (op == OP_BEQ)) begin
      r = 1'b1;
    end else begin
      r = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile32x32.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port,
// r0 hardwired to zero, and same-cycle write-to-read bypass.
module regfile32x32 #(
  parameter int WORD = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs_addr,
  input  logic [4:0]      rt_addr,
  output logic [WORD-1:0] rs_data,
  output logic [WORD-1:0] rt_data,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [WORD-1:0] wdata
);

  logic [WORD-1:0] mem_r [32];

  // Storage update; reset clears every entry, r0 is never written
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        mem_r[i] <= {WORD{1'b0}};
      end
    end else if (we && (waddr != 5'd0)) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read ports with bypass of the write landing this cycle
  always_comb begin
    rs_data = {WORD{1'b0}};
    rt_data = {WORD{1'b0}};
    if (rs_addr == 5'd0) begin
      rs_data = {WORD{1'b0}};
    end else if (we && (waddr == rs_addr)) begin
      rs_data = wdata;
    end else begin
      rs_data = mem_r[rs_addr];
    end
    if (rt_addr == 5'd0) begin
      rt_data = {WORD{1'b0}};
    end else if (we && (waddr == rt_addr)) begin
      rt_data = wdata;
    end else begin
      rt_data = mem_r[rt_addr];
    end
  end

endmodule

// File: rtl/idecode.sv
// venus instruction-decode stage: field split, register read, load-use hazard
// detection with a one-entry replay register, and the ID/EX pipeline register.
module idecode
  import venus_pkg::*;
#(
  parameter int              ADDR = 16,
  parameter int              WORD = 32,
  parameter logic [WORD-1:0] NOP  = NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WORD-1:0] inst_i,
  input  logic [ADDR-1:0] inst_addr_i,
  input  logic            flush_i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_addr_i,
  input  logic [WORD-1:0] wb_data_i,
  output logic            stall_o,
  output logic [5:0]      op_o,
  output logic [4:0]      rd_o,
  output logic [WORD-1:0] rs_data_o,
  output logic [WORD-1:0] rt_data_o,
  output logic [WORD-1:0] imm_o,
  output logic [ADDR-1:0] pc_o,
  output logic            is_load_o
);

  localparam logic [5:0] BUBBLE_OP = NOP[OP_HI:OP_LO];

  logic            replay_v_r;
  logic [WORD-1:0] replay_inst_r;
  logic [ADDR-1:0] replay_addr_r;

  logic [WORD-1:0] sel_inst_s;
  logic [ADDR-1:0] sel_addr_s;
  logic [5:0]      op_s;
  logic [4:0]      rd_s;
  logic [4:0]      rs_s;
  logic [4:0]      rt_s;
  logic [WORD-1:0] imm_s;
  logic [WORD-1:0] rs_data_s;
  logic [WORD-1:0] rt_data_s;
  logic            hit_s;
  logic            stall_s;

  regfile32x32 #(.WORD(WORD)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .rs_addr (rs_s),
    .rt_addr (rt_s),
    .rs_data (rs_data_s),
    .rt_data (rt_data_s),
    .we      (wb_we_i),
    .waddr   (wb_addr_i),
    .wdata   (wb_data_i)
  );

  // Source select and field split of the instruction being decoded
  always_comb begin
    sel_inst_s = inst_i;
    sel_addr_s = inst_addr_i;
    if (replay_v_r) begin
      sel_inst_s = replay_inst_r;
      sel_addr_s = replay_addr_r;
    end else begin
      sel_inst_s = inst_i;
      sel_addr_s = inst_addr_i;
    end
    op_s  = sel_inst_s[OP_HI:OP_LO];
    rd_s  = sel_inst_s[RD_HI:RD_LO];
    rs_s  = sel_inst_s[RS_HI:RS_LO];
    rt_s  = sel_inst_s[RT_HI:RT_LO];
    imm_s = {{(WORD-16){sel_inst_s[IMM_HI]}}, sel_inst_s[IMM_HI:IMM_LO]};
  end

  // Load-use hazard: only registers the selected opcode really reads count
  always_comb begin
    hit_s = (rd_o != 5'd0) &&
            ((reads_rs(op_s) && (rs_s == rd_o)) || (reads_rt(op_s) && (rt_s == rd_o)));
    stall_s = is_load_o & hit_s & ~flush_i;
  end

  assign stall_o = stall_s;

  // Replay register; a flush or reset leaves it empty
  always_ff @(posedge clk) begin
    if (!rst) begin
      replay_v_r    <= 1'b0;
      replay_inst_r <= NOP;
      replay_addr_r <= {ADDR{1'b0}};
    end else begin
      replay_v_r <= stall_s;
      if (stall_s) begin
        replay_inst_r <= sel_inst_s;
        replay_addr_r <= sel_addr_s;
      end
    end
  end

  // ID/EX register: bubble on reset, flush or stall, decoded values otherwise
  always_ff @(posedge clk) begin
    if (!rst || flush_i || stall_s) begin
      op_o      <= BUBBLE_OP;
      rd_o      <= 5'd0;
      rs_data_o <= {WORD{1'b0}};
      rt_data_o <= {WORD{1'b0}};
      imm_o     <= {WORD{1'b0}};
      pc_o      <= {ADDR{1'b0}};
      is_load_o <= 1'b0;
    end else begin
      op_o      <= op_s;
      rd_o      <= rd_s;
      rs_data_o <= rs_data_s;
      rt_data_o <= rt_data_s;
      imm_o     <= imm_s;
      pc_o      <= sel_addr_s;
      is_load_o <= (op_s == OP_LOAD);
    end
  end

endmodule
